// File: rtl/board_state.sv
// board_state: 3x3 tic-tac-toe board keeper.
// It tells the position generator whether a candidate cell is free. On confirm it
// commits the mover's mark, then spends one CHECK cycle scoring the board for a
// win or a draw before handing the turn to the other side.
module board_state (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pos,
  input  logic        confirm,
  input  logic        new_game,
  output logic        pos_available,
  output logic [17:0] board,
  output logic        player,
  output logic [3:0]  move_count,
  output logic        move_done,
  output logic        illegal,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [17:0] r_board;
  logic        r_player;
  logic [3:0]  r_move_count;
  logic        r_illegal;
  logic [1:0]  r_winner;

  logic [1:0]  w_cells [16];
  logic [1:0]  w_code;
  logic        w_accept;
  logic        w_reject;
  logic        w_win;
  logic        w_full;

  // Cell lookup table indexed directly by pos; indices 9..15 read as "occupied"
  // so that an out-of-range pos can never look free.
  for (genvar g = 0; g < 16; g++) begin : g_cells
    if (g < 9) begin : g_real
      assign w_cells[g] = r_board[2*g +: 2];
    end else begin : g_pad
      assign w_cells[g] = 2'b11;
    end
  end

  // True when all three cells of one line hold the given code.
  function automatic logic line_win(input logic [17:0] b, input logic [1:0] c,
                                    input int a, input int m, input int z);
    line_win = (b[2*a +: 2] == c) && (b[2*m +: 2] == c) && (b[2*z +: 2] == c);
  endfunction

  assign w_code = r_player ? 2'b10 : 2'b01;
  assign w_full = (r_move_count == 4'd9);

  // Only the mover's code is scored: any earlier win would already have ended the game.
  assign w_win = line_win(r_board, w_code, 0, 1, 2) |
                 line_win(r_board, w_code, 3, 4, 5) |
                 line_win(r_board, w_code, 6, 7, 8) |
                 line_win(r_board, w_code, 0, 3, 6) |
                 line_win(r_board, w_code, 1, 4, 7) |
                 line_win(r_board, w_code, 2, 5, 8) |
                 line_win(r_board, w_code, 0, 4, 8) |
                 line_win(r_board, w_code, 2, 4, 6);

  assign pos_available = (r_state == S_PLAY) && (pos < 4'd9) && (w_cells[pos] == 2'b00);

  // new_game takes precedence, so a simultaneous confirm neither writes nor flags illegal.
  assign w_accept = confirm && !new_game && pos_available;
  assign w_reject = confirm && !new_game &&
                    (((r_state == S_PLAY) && !pos_available) || (r_state == S_OVER));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_PLAY;
    else       r_state <= w_next_state;
  end

  // Next-state logic: PLAY -> CHECK on an accepted move; CHECK resolves in one cycle.
  always_comb begin
    w_next_state = r_state;
    if (new_game) begin
      w_next_state = S_PLAY;
    end else begin
      case (r_state)
        S_PLAY:  if (w_accept) w_next_state = S_CHECK;
        S_CHECK: w_next_state = (w_win || w_full) ? S_OVER : S_PLAY;
        S_OVER:  w_next_state = S_OVER;
        default: w_next_state = S_PLAY;
      endcase
    end
  end

  // Output decode from state.
  always_comb begin
    move_done = 1'b0;
    game_over = 1'b0;
    case (r_state)
      S_CHECK: move_done = 1'b1;
      S_OVER:  game_over = 1'b1;
      default: ;
    endcase
  end

  // Board, turn, move counter, result and illegal pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_board      <= '0;
      r_player     <= 1'b0;
      r_move_count <= '0;
      r_illegal    <= 1'b0;
      r_winner     <= 2'b00;
    end else if (new_game) begin
      r_board      <= '0;
      r_player     <= 1'b0;
      r_move_count <= '0;
      r_illegal    <= 1'b0;
      r_winner     <= 2'b00;
    end else begin
      r_illegal <= w_reject;
      if (w_accept) begin
        for (int i = 0; i < 9; i++) begin
          if (pos == 4'(i)) r_board[2*i +: 2] <= w_code;
        end
        r_move_count <= r_move_count + 4'd1;
      end
      // A win keeps the mover as player; a full board leaves winner at 00 (draw).
      if (r_state == S_CHECK) begin
        if (w_win)        r_winner <= w_code;
        else if (!w_full) r_player <= ~r_player;
      end
    end
  end

  assign board      = r_board;
  assign player     = r_player;
  assign move_count = r_move_count;
  assign illegal    = r_illegal;
  assign winner     = r_winner;

endmodule

// File: doc/board_state.md
# board_state

Tic-tac-toe board keeper that sits directly downstream of the random position generator. It takes the candidate cell index `pos`, returns `pos_available` so the generator can keep searching or assert `confirm`, and on `confirm` commits the current player's mark. After each move it checks all 8 win lines, detects a draw, and alternates players. Display and player-input logic read `board`, `player`, `game_over` and `winner`.

## Interface
- No parameters: the board is fixed at 3x3, cells 0..8, row-major.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pos`  in  4  candidate cell index.
- `confirm`  in  1  commit request for `pos`; sampled each rising edge.
- `new_game`  in  1  synchronous clear request.
- `pos_available`  out  1  combinational: state==PLAY, `pos`<9, and cell `pos` is empty.
- `board`  out  18  cell i at [2i+1:2i]; 00 empty, 01 X, 10 O (11 is never written).
- `player`  out  1  side to move; 0 = X, 1 = O.
- `move_count`  out  4  marks placed, 0..9.
- `move_done`  out  1  high for exactly one cycle while in CHECK.
- `illegal`  out  1  registered one-cycle pulse for a rejected `confirm`.
- `game_over`  out  1  high while in OVER.
- `winner`  out  2  00 none/draw, 01 X, 10 O; valid when `game_over` is high.

## Operation
- States:
  - PLAY waits for a move.
  - CHECK evaluates the board that was just updated.
  - OVER is the terminal state.
- Reset, or `new_game` in any state, returns the block to:
  - state PLAY, `board`=0, `player`=0, `move_count`=0;
  - `winner`=00, `illegal`=0.
- `new_game` has priority over `confirm` in the same cycle. That `confirm` is dropped and raises no `illegal`.
- PLAY with `confirm` and `pos_available`:
  - write the player code (X→01, O→10) into cell `pos`;
  - increment `move_count`;
  - go to CHECK.
- PLAY with `confirm` while `pos_available`=0 (occupied cell or `pos`≥9):
  - the board is unchanged;
  - `illegal` pulses next cycle;
  - the state stays PLAY.
- CHECK evaluates the 8 lines on the registered board: rows {0,1,2},{3,4,5},{6,7,8}, columns {0,3,6},{1,4,7},{2,5,8}, diagonals {0,4,8},{2,4,6}.
  - A line whose three cells hold the mover's code → OVER, `winner` = mover code, `player` unchanged.
  - Else `move_count`==9 → OVER, `winner`=00.
  - Else toggle `player` and return to PLAY.
- CHECK lasts exactly one cycle. `confirm` during CHECK is ignored silently: no write, no `illegal`.
- OVER: `confirm` pulses `illegal` and changes nothing. Only `new_game` or `reset` leaves OVER.
- Only the mover's code is checked, because a prior win would already have ended the game.

## Timing
- Reset values: all outputs 0; `pos_available` is 1 iff `pos`<9.
- `pos_available` is combinational from `pos`, `board` and state; 0 latency. The generator may assert `confirm` in the same cycle it sees `pos_available`=1.
- Accepted move, `confirm` sampled at edge N:
  - `board` and `move_count` update after edge N;
  - cycle N+1 is CHECK: `move_done`=1, `pos_available`=0;
  - after edge N+1: `player` toggles, or `game_over`/`winner` assert.
- Move throughput: one move per 2 cycles at most.
- `illegal` is registered: it is high during the cycle after the offending edge.
- Asynchronous `reset` mid-CHECK or in OVER forces the reset values immediately. No partial move survives.
- Back-to-back `confirm` held high: the first is accepted, the CHECK-cycle copy is ignored, and it is re-evaluated in the next PLAY cycle against the updated board.

## Test plan
- Reset and boundary values:
  - assert `reset`, release, then drive `pos`=4 → `board`=0, `player`=0, `move_count`=0, `game_over`=0, `pos_available`=1;
  - `pos`=9 and `pos`=15 → `pos_available`=0;
  - `confirm` with `pos`=12 → `illegal` 1 cycle, `board` unchanged.
- X row win: moves 0,3,1,4,2 (X,O,X,O,X), each a 1-cycle `confirm` followed by the CHECK cycle.
  - After the final CHECK edge: `game_over`=1, `winner`=01, `move_count`=5, `player`=0.
  - `board` = 18'b00_00_00_00_10_10_01_01_01.
- Occupied cell: X takes 4, then O confirms `pos`=4 → `illegal` pulses, cell 4 stays 01, `player`=1, `move_count`=1.
- Draw: moves 0,1,2,4,3,5,7,6,8 → `game_over`=1, `winner`=00, `move_count`=9; a further `confirm` → `illegal` pulse only.
- `new_game` priority: during the CHECK cycle after the third move, assert `new_game` together with `confirm`.
  - Next cycle: all cleared, state PLAY, `illegal`=0.
  - A following `confirm` `pos`=0 writes 01.
- Asynchronous reset mid-game: after 3 moves, pulse `reset` between clock edges → `board`, `move_count`, `player` = 0 before the next edge.
